// File: rtl/nes_pad_reader_if.sv
// Signal bundle between the NES pad reader and its frame/controller/paddle neighbours.
// master is the reader side; slave is the environment driving strobe and serial data.
interface nes_pad_reader_if;
  logic       vSyncStart;
  logic       nesData;
  logic       nesLatch;
  logic       nesClock;
  logic [7:0] buttons;
  logic       buttonsValid;
  logic       busy;

  modport master (
    input  vSyncStart,
    input  nesData,
    output nesLatch,
    output nesClock,
    output buttons,
    output buttonsValid,
    output busy
  );

  modport slave (
    output vSyncStart,
    output nesData,
    input  nesLatch,
    input  nesClock,
    input  buttons,
    input  buttonsValid,
    input  busy
  );
endinterface

// File: rtl/nes_pad_reader.sv
// Once-per-frame serial reader for a 4021-based NES controller; presents an active-high
// button byte with a one-cycle valid pulse.
module nes_pad_reader #(
  parameter int unsigned halfBitCycles = 300
) (
  input logic              pixelClock,
  input logic              reset,
  nes_pad_reader_if.master bus
);

  localparam int unsigned countWidth = $clog2(2 * halfBitCycles);
  localparam logic [countWidth-1:0] latchLast = countWidth'(2 * halfBitCycles - 1);
  localparam logic [countWidth-1:0] halfLast  = countWidth'(halfBitCycles - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StClkHigh, StClkLow, StDone} state_e;

  state_e                state;
  logic [countWidth-1:0] halfCount;
  logic [2:0]            bitCount;
  logic [7:0]            shiftReg;
  logic                  dataMeta;
  logic                  dataSync;
  logic                  nesLatch;
  logic                  nesClock;
  logic [7:0]            buttons;
  logic                  buttonsValid;
  logic                  busy;

  // nesData comes straight from the connector pin.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      dataMeta <= 1'b1;
      dataSync <= 1'b1;
    end else begin
      dataMeta <= bus.nesData;
      dataSync <= dataMeta;
    end
  end

  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      halfCount    <= '0;
      bitCount     <= '0;
      shiftReg     <= '0;
      nesLatch     <= 1'b0;
      nesClock     <= 1'b0;
      buttons      <= '0;
      buttonsValid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      buttonsValid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.vSyncStart) begin
            state     <= StLatch;
            nesLatch  <= 1'b1;
            busy      <= 1'b1;
            halfCount <= '0;
          end
        end
        StLatch: begin
          if (halfCount == latchLast) begin
            // A is already on the data line once the latch has been held.
            shiftReg  <= {dataSync, shiftReg[7:1]};
            nesLatch  <= 1'b0;
            nesClock  <= 1'b1;
            halfCount <= '0;
            bitCount  <= '0;
            state     <= StClkHigh;
          end else begin
            halfCount <= halfCount + 1'b1;
          end
        end
        StClkHigh: begin
          if (halfCount == halfLast) begin
            nesClock  <= 1'b0;
            halfCount <= '0;
            state     <= StClkLow;
          end else begin
            halfCount <= halfCount + 1'b1;
          end
        end
        StClkLow: begin
          if (halfCount == halfLast) begin
            halfCount <= '0;
            if (bitCount == 3'd7) begin
              state <= StDone;
            end else begin
              shiftReg <= {dataSync, shiftReg[7:1]};
              bitCount <= bitCount + 1'b1;
              nesClock <= 1'b1;
              state    <= StClkHigh;
            end
          end else begin
            halfCount <= halfCount + 1'b1;
          end
        end
        StDone: begin
          buttons      <= ~shiftReg;
          buttonsValid <= 1'b1;
          busy         <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.nesLatch     = nesLatch;
  assign bus.nesClock     = nesClock;
  assign bus.buttons      = buttons;
  assign bus.buttonsValid = buttonsValid;
  assign bus.busy         = busy;

endmodule
